// File: rtl/mem_byte_sequencer_pkg.sv
// Shared types and helpers for the byte-serial load/store sequencer.
// Ctrl codes match the data-memory encoding used by the MEM stage.
package mem_byte_sequencer_pkg;

    typedef logic [2:0] mem_ctrl_t;

    localparam mem_ctrl_t MEM_B  = 3'b000;
    localparam mem_ctrl_t MEM_H  = 3'b001;
    localparam mem_ctrl_t MEM_W  = 3'b010;
    localparam mem_ctrl_t MEM_BU = 3'b100;
    localparam mem_ctrl_t MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StResp
    } state_e;

    function automatic logic [2:0] size_bytes(input mem_ctrl_t ctrl);
        case (ctrl[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Unsigned variants only make sense for loads.
    function automatic logic is_legal(input mem_ctrl_t ctrl, input logic we);
        case (ctrl)
            MEM_B, MEM_H, MEM_W: return 1'b1;
            MEM_BU, MEM_HU:      return !we;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer_if.sv
// Pipeline request/response and byte-wide memory bus of the sequencer.
// master = sequencer side, slave = pipeline plus memory side.
interface mem_byte_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_ctrl;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;

    modport master (
        input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_byte_sequencer_load_extend.sv
// Sign/zero extension of the right-justified assembled load value by ctrl code.
module mem_byte_sequencer_load_extend
    import mem_byte_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] raw,
    input  mem_ctrl_t       ctrl,
    output logic [XLEN-1:0] data
);
    always_comb begin
        data = raw;
        case (ctrl)
            MEM_B:   data = {{(XLEN-8){raw[7]}}, raw[7:0]};
            MEM_H:   data = {{(XLEN-16){raw[15]}}, raw[15:0]};
            MEM_BU:  data = {{(XLEN-8){1'b0}}, raw[7:0]};
            MEM_HU:  data = {{(XLEN-16){1'b0}}, raw[15:0]};
            default: data = raw;
        endcase
    end
endmodule

// File: rtl/mem_byte_sequencer.sv
// Turns one byte/half/word load or store into big-endian single-byte transfers
// on an 8-bit request/ready bus and returns one extended response per request.
module mem_byte_sequencer
    import mem_byte_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
) (
    input logic                 clk,
    input logic                 rst,
    mem_byte_sequencer_if.master bus
);
    state_e            state_q, state_d;
    logic              we_q;
    mem_ctrl_t         ctrl_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [1:0]        last_q;
    logic [1:0]        cnt_q;
    logic [XLEN-9:0]   shift_q;
    logic              rsp_err_q;
    logic [XLEN-1:0]   rsp_rdata_q;

    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [1:0]        wbyte_idx;
    logic [XLEN-1:0]   shift_next;
    logic [XLEN-1:0]   ext_data;
    logic [2:0]        req_nbytes;
    logic              last_beat;

    assign req_nbytes = size_bytes(bus.req_ctrl);
    assign shift_next = {shift_q, bus.mem_rdata};
    assign wbyte_idx  = last_q - cnt_q;
    assign last_beat  = bus.mem_ready && (cnt_q == last_q);

    mem_byte_sequencer_load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .raw  (shift_next),
        .ctrl (ctrl_q),
        .data (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    state_d = is_legal(bus.req_ctrl, bus.req_we) ? StXfer : StResp;
                end
            end
            StXfer: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q + ADDR_W'(cnt_q);
                // Byte N-1-k of the store data, so bits [7:0] go out last.
                mem_wdata = wdata_q[{wbyte_idx, 3'b000} +: 8];
                if (last_beat) begin
                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            ctrl_q      <= MEM_B;
            addr_q      <= '0;
            wdata_q     <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && bus.req_valid) begin
                we_q    <= bus.req_we;
                ctrl_q  <= bus.req_ctrl;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                last_q  <= 2'(req_nbytes - 3'd1);
                cnt_q   <= '0;
                shift_q <= '0;
                if (!is_legal(bus.req_ctrl, bus.req_we)) begin
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                end
            end
            if (state_q == StXfer && bus.mem_ready) begin
                cnt_q <= cnt_q + 2'd1;
                if (!we_q) begin
                    shift_q <= shift_next[XLEN-9:0];
                end
                if (cnt_q == last_q) begin
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= we_q ? '0 : ext_data;
                end
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer: stores, signed/unsigned loads, wrap with
// stalls, illegal codes and reset in the middle of a transfer.
module tb_mem_byte_sequencer;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_byte_sequencer_if #(.ADDR_W(32), .XLEN(32)) bus ();

    mem_byte_sequencer #(.ADDR_W(32), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0020: rom = 8'h80;
            32'h0000_0031: rom = 8'h9A;
            32'h0000_0032: rom = 8'h55;
            32'hFFFF_FFFE: rom = 8'hF1;
            32'hFFFF_FFFF: rom = 8'h22;
            32'h0000_0000: rom = 8'h33;
            32'h0000_0001: rom = 8'h44;
            default:       rom = 8'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: req_ready=%b required 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_ctrl  = ctrl;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_ctrl  = 3'b000;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b1;
        #2;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/valid/err=%b%b%b required 100",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err);
        end
        n_checks++;
        if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem: en/we=%b%b required 00", bus.mem_en, bus.mem_we);
        end
        n_checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 8'h0 || bus.rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required zeros",
                     bus.mem_addr, bus.mem_wdata, bus.rsp_rdata);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_load(input string name, input logic [2:0] ctrl, input logic [31:0] addr,
                           input int n, input logic [31:0] expect_data);
        bus.mem_ready = 1'b1;
        issue(1'b0, ctrl, addr, 32'h0);
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== addr + 32'(k)) begin
                n_fail++;
                $display("FAIL %s_byte%0d: en=%b we=%b addr=%h required 1 0 %h",
                         name, k, bus.mem_en, bus.mem_we, bus.mem_addr, addr + 32'(k));
            end
            bus.mem_rdata = rom(addr + 32'(k));
            tick();
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== expect_data || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_rsp: valid=%b rdata=%h err=%b required 1 %h 0",
                     name, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, expect_data);
        end
        tick();
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_after: valid=%b ready=%b required 0 1",
                     name, bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_byte_load();
        do_load("lb", 3'b000, 32'h20, 1, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h20, 1, 32'h0000_0080);
    endtask

    task automatic test_half_load();
        do_load("lh", 3'b001, 32'h31, 2, 32'hFFFF_9A55);
        do_load("lhu", 3'b101, 32'h31, 2, 32'h0000_9A55);
    endtask

    task automatic test_wrap_stall();
        logic        pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] base = 32'hFFFF_FFFE;
        int          k = 0;
        issue(1'b0, 3'b010, base, 32'h0);
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = pat[i];
            n_checks++;
            if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== base + 32'(k)
                || bus.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_cycle%0d: en=%b we=%b addr=%h valid=%b required 1 0 %h 0",
                         i, bus.mem_en, bus.mem_we, bus.mem_addr, bus.rsp_valid, base + 32'(k));
            end
            bus.mem_rdata = rom(base + 32'(k));
            tick();
            if (pat[i]) k++;
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hF122_3344 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_rsp: valid=%b rdata=%h err=%b required 1 f1223344 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        tick();
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_once: valid=%b en=%b required 0 0", bus.rsp_valid, bus.mem_en);
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_illegal();
        logic [2:0]  ctrls [2] = '{3'b011, 3'b100};
        logic        wes   [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            issue(wes[i], ctrls[i], 32'h40, 32'h0000_00AB);
            n_checks++;
            if (bus.mem_en !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1
                || bus.rsp_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL illegal%0d_rsp: en=%b valid=%b err=%b rdata=%h required 0 1 1 0",
                         i, bus.mem_en, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
            end
            tick();
            n_checks++;
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_err !== 1'b1
                || bus.mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal%0d_after: valid=%b ready=%b err=%b en=%b required 0 1 1 0",
                         i, bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.mem_en);
            end
        end
    endtask

    task automatic test_word_store();
        logic [7:0] exp_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        bus.mem_ready = 1'b1;
        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h10 + 32'(k)
                || bus.mem_wdata !== exp_b[k] || bus.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sw_byte%0d: en=%b we=%b addr=%h wdata=%h valid=%b required 1 1 %h %h 0",
                         k, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rsp_valid,
                         32'h10 + 32'(k), exp_b[k]);
            end
            tick();
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0
            || bus.req_ready !== 1'b0 || bus.mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_rsp: valid=%b rdata=%h err=%b ready=%b en=%b required 1 0 0 0 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, bus.mem_en);
        end
        tick();
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL sw_ready: ready=%b valid=%b rdata=%h required 1 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b [2] = '{8'h01, 8'h02};
        int         writes = 0;
        bus.mem_ready = 1'b1;
        issue(1'b1, 3'b010, 32'h50, 32'h0102_0304);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (bus.mem_addr !== 32'h50 + 32'(k) || bus.mem_wdata !== exp_b[k]) begin
                n_fail++;
                $display("FAIL rstmid_byte%0d: addr=%h wdata=%h required %h %h",
                         k, bus.mem_addr, bus.mem_wdata, 32'h50 + 32'(k), exp_b[k]);
            end
            if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) writes++;
            tick();
        end
        n_checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h52 || bus.mem_wdata !== 8'h03) begin
            n_fail++;
            $display("FAIL rstmid_third: en=%b addr=%h wdata=%h required 1 00000052 03",
                     bus.mem_en, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_en !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0
            || bus.mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_abort: en=%b ready=%b valid=%b addr=%h required 0 1 0 0",
                     bus.mem_en, bus.req_ready, bus.rsp_valid, bus.mem_addr);
        end
        n_checks++;
        if (writes != 2) begin
            n_fail++;
            $display("FAIL rstmid_writes: completed byte writes=%0d required 2", writes);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.rsp_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid_quiet%0d: valid=%b en=%b ready=%b required 0 0 1",
                         i, bus.rsp_valid, bus.mem_en, bus.req_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_load();
        test_half_load();
        test_wrap_stall();
        test_illegal();
        test_word_store();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_byte_sequencer.md
Name: mem_byte_sequencer

Overview:
- Initiator that sits between the pipeline MEM stage and the byte-wide data memory port.
- Accepts one load/store request: byte, halfword or word, using the same 3-bit control encoding as the data memory.
- Performs it as a sequence of single-byte transfers over an 8-bit request/ready memory bus.
- Assembles load data with sign/zero extension and returns one response per request; the pipeline stalls on req_ready low.

Parameters:
- ADDR_W, 32, width of byte address.
- XLEN, 32, width of request/response data.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  pipeline presents a memory op
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_ctrl  in  3  000 byte s, 001 half s, 010 word, 100 byte u, 101 half u
- req_addr  in  ADDR_W  byte address of first (most significant) byte
- req_wdata  in  XLEN  store data, right-justified
- rsp_valid  out  1  one-cycle pulse, op complete
- rsp_rdata  out  XLEN  extended load data (0 for stores/errors)
- rsp_err  out  1  with rsp_valid: illegal ctrl code
- mem_en  out  1  byte transfer request
- mem_we  out  1  byte write
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  byte read, valid when mem_en && mem_ready
- mem_ready  in  1  memory completes current byte this cycle

Behaviour:
- Reset (async, immediate):
  - state IDLE; req_ready=1.
  - rsp_valid, rsp_err, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, rsp_rdata = 0.
  - Byte counter and data shift register = 0.
- Reset mid-operation: transfer aborts, mem_en drops asynchronously, no response; bytes already written stay in memory.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - req_valid=1 latches we, ctrl, addr, wdata.
  - Legal code: N = 1/2/4 bytes from ctrl[1:0], k=0, go XFER.
  - Illegal code (011, 110, 111; or 100/101 with req_we=1): go RESP with err=1, no memory access.
- XFER:
  - mem_en=1, mem_we=we, mem_addr = addr + k (mod 2^ADDR_W, wraps at top).
  - Big-endian order: k=0 is the most significant byte of the N-byte quantity.
  - mem_wdata = byte (N-1-k) of wdata, so bits [7:0] are written last at addr+N-1.
  - When mem_ready=1: loads shift mem_rdata into the low end of the shift register; k increments.
  - Last byte (k=N-1) with mem_ready → RESP.
  - mem_ready=0: all mem_* outputs hold stable.
- RESP:
  - rsp_valid=1 for exactly one cycle; next state IDLE.
  - Signed loads sign-extend from bit 7 of byte 0; unsigned loads zero-extend.
  - rsp_rdata and rsp_err are registered and held until the next response.
- Latency with mem_ready tied high, accepted at cycle T: bytes at T+1..T+N, rsp_valid at T+N+1, req_ready back high at T+N+2.
- req_valid outside IDLE is ignored (not latched); the pipeline must hold the request until req_ready.
- No alignment restriction: unaligned halfword/word is legal and simply sequenced.

Decomposition:
- Shared package mem_pkg:
  - Typedef for the 3-bit ctrl encoding with named constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU).
  - FSM state enum.
  - Function size_bytes(ctrl) and function is_legal(ctrl, we).
- One natural sub-module: mem_load_extend (combinational sign/zero extension of the assembled 32-bit shift register by ctrl).

Test Plan:
- Word store, addr 0x10, wdata 0xDEADBEEF, mem_ready=1 → bytes DE,AD,BE,EF written to 0x10..0x13 on 4 consecutive cycles; rsp_valid at T+5, rsp_rdata=0, rsp_err=0.
- Signed byte load, memory[0x20]=0x80 → rsp_rdata=0xFFFFFF80; same address with ctrl 100 → 0x00000080.
- Signed halfword load at odd addr 0x31, mem[0x31]=0x9A, mem[0x32]=0x55 → rsp_rdata=0xFFFF9A55; unsigned → 0x00009A55.
- Word load at 0xFFFFFFFE with mem_ready toggled 1,0,1,0,1,0,1 → addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001; outputs stable while mem_ready=0; rsp_valid once.
- req_ctrl=011 or store with ctrl 100 → no mem_en, rsp_valid with rsp_err=1 at T+1.
- rst asserted during the 3rd byte of a word store → mem_en low the same cycle, no rsp_valid, req_ready=1; bytes 0–1 remain written.
